// File: rtl/axadd_pkg.sv
// Shared definitions for the approximate-adder sharing controller:
// datapath widths, controller state encoding and the exact reference sum.
package axadd_pkg;

    localparam int ADD_W = 16;
    localparam int SUM_W = 17;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Exact reference sum against which the approximate adder is judged
    function automatic logic [SUM_W-1:0] exact_sum(input logic [ADD_W-1:0] a,
                                                   input logic [ADD_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/axadd_share_arbiter_rr_arbiter.sv
// Round-robin grant: picks the first asserted request at or after ptr,
// searching upward with wrap, and reports it one-hot and encoded.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_any
);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!gnt_any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = ID_W'(idx);
                gnt_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axadd_share_arbiter.sv
// Shares one external approximate 16-bit adder among NUM_REQ requesters,
// returning registered results and keeping accuracy statistics.
module axadd_share_arbiter
    import axadd_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*ADD_W-1:0] req_a,
    input  logic [NUM_REQ*ADD_W-1:0] req_b,
    output logic [ADD_W-1:0]         add_a,
    output logic [ADD_W-1:0]         add_b,
    input  logic [SUM_W-1:0]         add_sum,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [SUM_W-1:0]         rsp_sum,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     rsp_err,
    input  logic                     stat_clr,
    output logic [CNT_W-1:0]         op_cnt,
    output logic [CNT_W-1:0]         err_cnt
);

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q;
    logic [ID_W-1:0]     ptr_next;
    logic                issue;
    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gnt_idx;
    logic                gnt_any;
    logic                mismatch;

    // Gating with rst keeps the handshake closed during reset, so nothing
    // granted in a reset cycle can be lost silently
    assign issue = !rst && ((state_q == IDLE) || rsp_ready);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req     (req_valid & {NUM_REQ{issue}}),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign req_ready = gnt;
    assign rsp_valid = (state_q == HOLD);
    assign mismatch  = (add_sum != exact_sum(add_a, add_b));
    assign ptr_next  = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                add_a = req_a[i*ADD_W +: ADD_W];
                add_b = req_b[i*ADD_W +: ADD_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (gnt_any) begin
            state_d = HOLD;
        end else if (state_q == HOLD && rsp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rsp_sum <= '0;
            rsp_id  <= '0;
            rsp_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (gnt_any) begin
                ptr_q   <= ptr_next;
                rsp_sum <= add_sum;
                rsp_id  <= gnt_idx;
                rsp_err <= mismatch;
            end
        end
    end

    // Statistics saturate rather than wrap; a clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            op_cnt  <= '0;
            err_cnt <= '0;
        end else if (gnt_any) begin
            if (op_cnt != '1) begin
                op_cnt <= op_cnt + CNT_W'(1);
            end
            if (mismatch && err_cnt != '1) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_axadd_share_arbiter.sv
// Directed bench: table-driven single operations plus hand-written fairness,
// backpressure, saturation/clear and reset sequences.
module tb_axadd_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*16-1:0] req_a;
    logic [NUM_REQ*16-1:0] req_b;
    logic [15:0]          add_a;
    logic [15:0]          add_b;
    logic [16:0]          add_sum;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [16:0]          rsp_sum;
    logic [ID_W-1:0]      rsp_id;
    logic                 rsp_err;
    logic                 stat_clr;
    logic [CNT_W-1:0]     op_cnt;
    logic [CNT_W-1:0]     err_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] sum;
        logic        err;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    axadd_share_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .stat_clr  (stat_clr),
        .op_cnt    (op_cnt),
        .err_cnt   (err_cnt)
    );

    // Approximate adder model: carry out of the low 2-bit segment is dropped
    function automatic logic [16:0] approx_add(input logic [15:0] a, input logic [15:0] b);
        logic [14:0] hi;
        logic [2:0]  lo;
        hi = {1'b0, a[15:2]} + {1'b0, b[15:2]};
        lo = {1'b0, a[1:0]} + {1'b0, b[1:0]};
        return {hi, lo[1:0]};
    endfunction

    assign add_sum = approx_add(add_a, add_b);

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input int id, input logic [15:0] a, input logic [15:0] b);
        req_a[id*16 +: 16] = a;
        req_b[id*16 +: 16] = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        stat_clr  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{id: 1, a: 16'h0010, b: 16'h0020, sum: 17'h00030, err: 1'b0};
        vecs[1] = '{id: 2, a: 16'h0003, b: 16'h0001, sum: 17'h00000, err: 1'b1};
        vecs[2] = '{id: 3, a: 16'hFFFF, b: 16'h0001, sum: 17'h0FFFC, err: 1'b1};
        vecs[3] = '{id: 0, a: 16'hFFFC, b: 16'h0008, sum: 17'h10004, err: 1'b0};
        vecs[4] = '{id: 1, a: 16'h1235, b: 16'h0002, sum: 17'h01237, err: 1'b0};

        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1; stat_clr = 1'b0;
        do_reset();

        // Reset state
        #1;
        check_output("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("reset rsp_sum",   32'(rsp_sum),   32'd0);
        check_output("reset rsp_id",    32'(rsp_id),    32'd0);
        check_output("reset rsp_err",   32'(rsp_err),   32'd0);
        check_output("reset op_cnt",    32'(op_cnt),    32'd0);
        check_output("reset err_cnt",   32'(err_cnt),   32'd0);
        check_output("reset req_ready", 32'(req_ready), 32'd0);
        check_output("reset add_a",     32'(add_a),     32'd0);

        // Table-driven single operations
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            apply_stimulus(vecs[v].id, vecs[v].a, vecs[v].b);
            req_valid = NUM_REQ'(1) << vecs[v].id;
            #1;
            check_output($sformatf("vec%0d req_ready", v), 32'(req_ready), 32'(1) << vecs[v].id);
            @(negedge clk);
            req_valid = '0;
            check_output($sformatf("vec%0d rsp_valid", v), 32'(rsp_valid), 32'd1);
            check_output($sformatf("vec%0d rsp_sum", v),   32'(rsp_sum),   32'(vecs[v].sum));
            check_output($sformatf("vec%0d rsp_id", v),    32'(rsp_id),    32'(vecs[v].id));
            check_output($sformatf("vec%0d rsp_err", v),   32'(rsp_err),   32'(vecs[v].err));
            if (v == 0) begin
                check_output("vec0 op_cnt",  32'(op_cnt),  32'd1);
                check_output("vec0 err_cnt", 32'(err_cnt), 32'd0);
            end
            if (v == 1) begin
                check_output("vec1 err_cnt", 32'(err_cnt), 32'd1);
            end
        end
        @(negedge clk);
        check_output("table op_cnt",    32'(op_cnt),    32'd5);
        check_output("table err_cnt",   32'(err_cnt),   32'd2);
        check_output("table idle",      32'(rsp_valid), 32'd0);

        // Fairness: all requesters continuously valid
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) apply_stimulus(i, 16'(i + 1), 16'h0100);
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check_output($sformatf("fair%0d req_ready", k), 32'(req_ready), 32'(1) << (k % 4));
            if (k > 0) begin
                check_output($sformatf("fair%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
                check_output($sformatf("fair%0d rsp_id", k), 32'(rsp_id), 32'((k - 1) % 4));
                check_output($sformatf("fair%0d rsp_sum", k), 32'(rsp_sum), 32'h101 + 32'((k - 1) % 4));
            end
            @(negedge clk);
        end
        req_valid = '0;
        check_output("fair last rsp_id", 32'(rsp_id), 32'd3);
        check_output("fair op_cnt",      32'(op_cnt), 32'd8);

        // Backpressure: requesters 0 and 2 pending, consumer stalls 5 cycles
        @(negedge clk);
        req_valid = 4'b0101;
        #1;
        check_output("bp first grant", 32'(req_ready), 32'b0001);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            check_output($sformatf("bp%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
            check_output($sformatf("bp%0d rsp_id", k),    32'(rsp_id),    32'd0);
            check_output($sformatf("bp%0d rsp_sum", k),   32'(rsp_sum),   32'h101);
            check_output($sformatf("bp%0d req_ready", k), 32'(req_ready), 32'd0);
            @(negedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        #1;
        check_output("bp release grant", 32'(req_ready), 32'b0100);
        @(negedge clk);
        req_valid = '0;
        check_output("bp next rsp_id",  32'(rsp_id),  32'd2);
        check_output("bp next rsp_sum", 32'(rsp_sum), 32'h103);

        // Saturation with all-mismatching operands, then clear alongside a grant
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) apply_stimulus(i, 16'h0003, 16'h0001);
        req_valid = '1;
        repeat (17) @(negedge clk);
        check_output("sat op_cnt",  32'(op_cnt),  32'd15);
        check_output("sat err_cnt", 32'(err_cnt), 32'd15);
        stat_clr = 1'b1;
        #1;
        check_output("clr grant active", 32'(|req_ready), 32'd1);
        @(negedge clk);
        stat_clr  = 1'b0;
        req_valid = '0;
        check_output("clr op_cnt",  32'(op_cnt),  32'd0);
        check_output("clr err_cnt", 32'(err_cnt), 32'd0);

        // Reset while holding a stalled result
        rsp_ready = 1'b0;
        @(negedge clk);
        check_output("rst hold rsp_valid", 32'(rsp_valid), 32'd1);
        rst       = 1'b1;
        req_valid = '1;
        #1;
        check_output("rst req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("post rst rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("post rst op_cnt",    32'(op_cnt),    32'd0);
        check_output("post rst err_cnt",   32'(err_cnt),   32'd0);
        check_output("post rst grant",     32'(req_ready), 32'b0001);
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = '0;
        check_output("post rst rsp_id", 32'(rsp_id), 32'd0);
        check_output("post rst op_cnt1", 32'(op_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
